// File: rtl/debounce_sync.sv
// Synchronizer + stability-count debouncer for a raw asynchronous level.
// Define DEBOUNCE_EDGE_PULSE_EN to build the registered rise/fall pulses.
module debounce_sync #(
  parameter int   SYNC_STAGES   = 2,
  parameter int   STABLE_CYCLES = 16,
  parameter logic RESET_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in,
  output logic out,
  output logic rise,
  output logic fall,
  output logic busy
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be >= 2");
  end
  if (STABLE_CYCLES < 1) begin : g_bad_stable
    $error("STABLE_CYCLES must be >= 1");
  end

  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0]          cnt;
  logic                   s;
  logic                   hit;
  logic                   flip;

  assign s    = sync[SYNC_STAGES-1];
  assign hit  = (cnt == LAST);
  assign flip = (s != out) && hit;
  assign busy = |cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= {SYNC_STAGES{RESET_VAL}};
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], in};
    end
  end

  // Any sample agreeing with out aborts the candidate transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out <= RESET_VAL;
      cnt <= '0;
    end else if (s == out) begin
      cnt <= '0;
    end else if (hit) begin
      out <= s;
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

`ifdef DEBOUNCE_EDGE_PULSE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      rise <= flip && s;
      fall <= flip && !s;
    end
  end
`else
  logic unused_flip;
  assign unused_flip = flip;
  assign rise = 1'b0;
  assign fall = 1'b0;
`endif

endmodule

// File: tb/tb_debounce_sync.sv
// Scoreboard bench for debounce_sync with default parameters.
// Expected per-edge outputs come from a sample-window model of in.
module tb_debounce_sync;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic din = 1'b0;
  logic out, rise, fall, busy;

  int nchk = 0;
  int nfail = 0;
  int nrise = 0;
  int nfall = 0;

  bit hist[$];
  bit out_m = 1'b0;
  logic [3:0] sb[$];

  debounce_sync dut (
    .clk  (clk),
    .rst_n(rst_n),
    .in   (din),
    .out  (out),
    .rise (rise),
    .fall (fall),
    .busy (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Synchronized sample used at edge j (two-flop delay of in).
  function automatic bit samp(input int j);
    if (j < 2) return 1'b0;
    return hist[j-2];
  endfunction

  task automatic model_edge();
    int  k;
    bit  flip;
    bit  b;
    bit  r;
    bit  f;
    k    = hist.size() - 1;
    flip = 1'b1;
    for (int j = k - 15; j <= k; j++)
      if (samp(j) == out_m) flip = 1'b0;
    b = !flip && (samp(k) != out_m);
    r = 1'b0;
    f = 1'b0;
`ifdef DEBOUNCE_EDGE_PULSE_EN
    r = flip && !out_m;
    f = flip && out_m;
`endif
    if (flip) out_m = !out_m;
    sb.push_back({out_m, b, r, f});
  endtask

  task automatic step(input bit v, input string tag);
    logic [3:0] e;
    din = v;
    @(posedge clk);
    hist.push_back(v);
    model_edge();
    @(negedge clk);
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 1, 0);
    end else begin
      e = sb.pop_front();
      check(tag, {out, busy, rise, fall}, e);
    end
    if (rise) nrise++;
    if (fall) nfall++;
    if (rise && fall) check({tag, "_both"}, {rise, fall}, 2'b00);
  endtask

  task automatic do_reset(input bit v);
    din   = v;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_state", {out, busy, rise, fall}, 4'b0000);
    rst_n = 1'b1;
    hist.delete();
    sb.delete();
    out_m = 1'b0;
  endtask

  initial begin
    int lat;
    int r0;
    int f0;
    @(negedge clk);

    // Clean step
    do_reset(1'b0);
    for (int i = 0; i < 20; i++) step(1'b0, "clean_lo");
    lat = -1;
    r0  = nrise;
    for (int i = 0; i < 25; i++) begin
      step(1'b1, "clean_hi");
      if (out && lat < 0) lat = i;
      if (i == 1) check("clean_busy_e2", busy, 0);
      if (i == 2) check("clean_busy_e3", busy, 1);
      if (i == 16) check("clean_busy_e17", busy, 1);
    end
    check("clean_lat", lat, 17);
`ifdef DEBOUNCE_EDGE_PULSE_EN
    check("clean_rise_cnt", nrise - r0, 1);
`else
    check("clean_rise_cnt", nrise - r0, 0);
`endif

    // Short glitch
    do_reset(1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, "gl_lo");
    r0 = nrise;
    for (int i = 0; i < 15; i++) step(1'b1, "gl_hi");
    for (int i = 0; i < 3; i++) step(1'b0, "gl_back");
    check("gl_busy", busy, 0);
    check("gl_out", out, 0);
    check("gl_rise_cnt", nrise - r0, 0);

    // Threshold pulse
    for (int i = 0; i < 5; i++) step(1'b0, "th_lo");
    r0 = nrise;
    f0 = nfall;
    for (int i = 0; i < 16; i++) step(1'b1, "th_hi");
    for (int i = 0; i < 24; i++) step(1'b0, "th_lo2");
    check("th_out_end", out, 0);
`ifdef DEBOUNCE_EDGE_PULSE_EN
    check("th_rise_cnt", nrise - r0, 1);
    check("th_fall_cnt", nfall - f0, 1);
`else
    check("th_rise_cnt", nrise - r0, 0);
    check("th_fall_cnt", nfall - f0, 0);
`endif

    // Bouncing input
    r0 = nrise;
    for (int i = 0; i < 30; i++) begin
      step(((i / 3) % 2) == 0, "bnc");
      check("bnc_out", out, 0);
    end
    lat = -1;
    for (int i = 0; i < 22; i++) begin
      step(1'b1, "bnc_hold");
      if (out && lat < 0) lat = i;
    end
    check("bnc_lat", lat, 17);
`ifdef DEBOUNCE_EDGE_PULSE_EN
    check("bnc_rise_cnt", nrise - r0, 1);
`else
    check("bnc_rise_cnt", nrise - r0, 0);
`endif

    // Reset mid-count
    do_reset(1'b1);
    for (int i = 0; i < 10; i++) step(1'b1, "rm_cnt");
    check("rm_busy_pre", busy, 1);
    #2 rst_n = 1'b0;
    #1 check("rm_async", {out, busy, rise, fall}, 4'b0000);
    do_reset(1'b1);
    lat = -1;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, "rm_rel");
      if (out && lat < 0) lat = i;
    end
    check("rm_lat", lat, 17);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

endmodule
